// File: rtl/ltc2312_burst_ctrl.sv
// Burst acquisition sequencer for an LTC2312 SPI ADC reader: arm, trigger, holdoff,
// box-car averaging and a single-entry AXI-Stream style output register.
module ltc2312_burst_ctrl #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             abort,
    input  logic             trig,
    input  logic [LEN_W-1:0] burst_len,
    input  logic [2:0]       avg_log2,
    input  logic [LEN_W-1:0] holdoff,
    input  logic [WIDTH-1:0] adc_tdata,
    input  logic             adc_tvalid,
    output logic             adc_enable,
    output logic             adc_clear,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tvalid,
    output logic             o_tlast,
    input  logic             o_tready,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam int unsigned AccW = WIDTH + 4;

    typedef enum logic [2:0] {StIdle, StArmed, StHoldoff, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic              trig_q;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [2:0]        avg_q, avg_d;
    logic [LEN_W-1:0]  hold_q, hold_d;
    logic [LEN_W-1:0]  hcnt_q, hcnt_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic [4:0]        scnt_q, scnt_d;
    logic [LEN_W-1:0]  wcnt_q, wcnt_d;
    logic [WIDTH-1:0]  tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic              ovf_q, ovf_d;
    logic              clear_q, clear_d;
    logic              done_q, done_d;

    logic [AccW-1:0]   sum;
    logic [AccW-1:0]   sum_shr;
    logic              grp_last;
    logic [LEN_W-1:0]  wcnt_inc;
    logic              out_free;

    assign sum      = acc_q + AccW'(adc_tdata);
    assign sum_shr  = sum >> avg_q;
    assign grp_last = (scnt_q + 5'd1) == (5'd1 << avg_q);
    assign wcnt_inc = wcnt_q + LEN_W'(1);
    assign out_free = !tvalid_q || o_tready;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        avg_d    = avg_q;
        hold_d   = hold_q;
        hcnt_d   = hcnt_q;
        acc_d    = acc_q;
        scnt_d   = scnt_q;
        wcnt_d   = wcnt_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        ovf_d    = ovf_q;
        clear_d  = 1'b0;
        done_d   = 1'b0;

        if (tvalid_q && o_tready) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (arm && (burst_len != '0)) begin
                    len_d   = burst_len;
                    avg_d   = (avg_log2 > 3'd4) ? 3'd4 : avg_log2;
                    hold_d  = holdoff;
                    ovf_d   = 1'b0;
                    wcnt_d  = '0;
                    acc_d   = '0;
                    scnt_d  = '0;
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (trig && !trig_q) begin
                    if (hold_q == '0) begin
                        state_d = StRun;
                    end else begin
                        hcnt_d  = hold_q;
                        state_d = StHoldoff;
                    end
                end
            end
            StHoldoff: begin
                if (hcnt_q == LEN_W'(1)) begin
                    state_d = StRun;
                end else begin
                    hcnt_d = hcnt_q - LEN_W'(1);
                end
            end
            StRun: begin
                if (adc_tvalid) begin
                    if (grp_last) begin
                        acc_d  = '0;
                        scnt_d = '0;
                        wcnt_d = wcnt_inc;
                        if (out_free) begin
                            tdata_d  = sum_shr[WIDTH-1:0];
                            tvalid_d = 1'b1;
                            tlast_d  = (wcnt_inc == len_q);
                        end else begin
                            ovf_d = 1'b1;
                        end
                        // A dropped final word still terminates the burst.
                        if (wcnt_inc == len_q) begin
                            state_d = StDone;
                            clear_d = 1'b1;
                        end
                    end else begin
                        acc_d  = sum;
                        scnt_d = scnt_q + 5'd1;
                    end
                end
            end
            StDone: begin
                if (!tvalid_d) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort) begin
            state_d  = StIdle;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            acc_d    = '0;
            scnt_d   = '0;
            ovf_d    = ovf_q;
            clear_d  = 1'b1;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            trig_q   <= 1'b0;
            len_q    <= '0;
            avg_q    <= '0;
            hold_q   <= '0;
            hcnt_q   <= '0;
            acc_q    <= '0;
            scnt_q   <= '0;
            wcnt_q   <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            ovf_q    <= 1'b0;
            clear_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            trig_q   <= trig;
            len_q    <= len_d;
            avg_q    <= avg_d;
            hold_q   <= hold_d;
            hcnt_q   <= hcnt_d;
            acc_q    <= acc_d;
            scnt_q   <= scnt_d;
            wcnt_q   <= wcnt_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            ovf_q    <= ovf_d;
            clear_q  <= clear_d;
            done_q   <= done_d;
        end
    end

    assign adc_enable = (state_q == StRun);
    assign busy       = (state_q != StIdle);
    assign adc_clear  = clear_q;
    assign o_tdata    = tdata_q;
    assign o_tvalid   = tvalid_q;
    assign o_tlast    = tlast_q;
    assign done       = done_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_ltc2312_burst_ctrl.sv
// Directed bench for ltc2312_burst_ctrl; expected beats go into a queue that a
// forked monitor drains on every output handshake.
module tb_ltc2312_burst_ctrl;

    localparam int unsigned WIDTH = 14;
    localparam int unsigned LEN_W = 16;

    logic             clk;
    logic             rst;
    logic             arm;
    logic             abort;
    logic             trig;
    logic [LEN_W-1:0] burst_len;
    logic [2:0]       avg_log2;
    logic [LEN_W-1:0] holdoff;
    logic [WIDTH-1:0] adc_tdata;
    logic             adc_tvalid;
    logic             adc_enable;
    logic             adc_clear;
    logic [WIDTH-1:0] o_tdata;
    logic             o_tvalid;
    logic             o_tlast;
    logic             o_tready;
    logic             busy;
    logic             done;
    logic             overflow;

    int checks;
    int errors;
    int done_cnt;
    logic [WIDTH:0] exp_q[$];

    ltc2312_burst_ctrl #(
        .WIDTH(WIDTH),
        .LEN_W(LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .abort     (abort),
        .trig      (trig),
        .burst_len (burst_len),
        .avg_log2  (avg_log2),
        .holdoff   (holdoff),
        .adc_tdata (adc_tdata),
        .adc_tvalid(adc_tvalid),
        .adc_enable(adc_enable),
        .adc_clear (adc_clear),
        .o_tdata   (o_tdata),
        .o_tvalid  (o_tvalid),
        .o_tlast   (o_tlast),
        .o_tready  (o_tready),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input logic last, input logic [WIDTH-1:0] data);
        exp_q.push_back({last, data});
    endtask

    task automatic monitor();
        logic [WIDTH:0] e;
        forever begin
            @(negedge clk);
            if (rst && o_tvalid && o_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got last=%0b data=%0h expected none",
                             o_tlast, o_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_tlast, o_tdata} !== e) begin
                        errors++;
                        $display("FAIL beat: got last=%0b data=%0h expected last=%0b data=%0h",
                                 o_tlast, o_tdata, e[WIDTH], e[WIDTH-1:0]);
                    end
                end
            end
            if (rst && done) done_cnt++;
        end
    endtask

    task automatic arm_cfg(input logic [LEN_W-1:0] len, input logic [2:0] avg,
                           input logic [LEN_W-1:0] hold);
        burst_len = len;
        avg_log2  = avg;
        holdoff   = hold;
        arm       = 1'b1;
        cyc(1);
        arm       = 1'b0;
    endtask

    task automatic fire_trig();
        trig = 1'b1;
        cyc(1);
        trig = 1'b0;
    endtask

    task automatic sample(input logic [WIDTH-1:0] d);
        adc_tdata  = d;
        adc_tvalid = 1'b1;
        cyc(1);
        adc_tvalid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int found;
        found = 0;
        for (int k = 0; k < 50; k++) begin
            cyc(1);
            if (done) begin
                found = 1;
                break;
            end
        end
        check({name, "_done_seen"}, found, 1);
        check({name, "_busy_with_done"}, busy, 0);
    endtask

    initial begin
        int lat;
        int dsnap;
        checks     = 0;
        errors     = 0;
        done_cnt   = 0;
        arm        = 1'b0;
        abort      = 1'b0;
        trig       = 1'b0;
        burst_len  = '0;
        avg_log2   = '0;
        holdoff    = '0;
        adc_tdata  = '0;
        adc_tvalid = 1'b0;
        o_tready   = 1'b1;
        rst        = 1'b0;
        fork
            monitor();
        join_none
        cyc(2);
        check("reset_outputs",
              {adc_enable, adc_clear, o_tvalid, o_tlast, busy, done, overflow, 14'(o_tdata)}, 0);
        rst = 1'b1;
        cyc(1);

        // Basic burst, no averaging, no holdoff.
        arm_cfg(16'd4, 3'd0, 16'd0);
        check("basic_busy_after_arm", busy, 1);
        fire_trig();
        check("basic_enable_t1", adc_enable, 1);
        for (int i = 0; i < 4; i++) push(i == 3, 14'h100 + 14'(i));
        for (int i = 0; i < 4; i++) sample(14'h100 + 14'(i));
        check("basic_last_word", {o_tvalid, o_tlast, 14'(o_tdata)}, {2'b11, 14'h103});
        check("basic_enable_fall_clear", {adc_enable, adc_clear, busy}, 3'b011);
        wait_done("basic");
        cyc(1);
        check("basic_done_one_cycle", done, 0);
        check("basic_overflow", overflow, 0);

        // Averaging: 4 samples and 16 full-scale samples.
        arm_cfg(16'd1, 3'd2, 16'd0);
        fire_trig();
        push(1'b1, 14'd11);
        sample(14'd10); sample(14'd11); sample(14'd12); sample(14'd14);
        wait_done("avg4");
        arm_cfg(16'd1, 3'd6, 16'd0);
        fire_trig();
        push(1'b1, 14'h3FFF);
        for (int i = 0; i < 16; i++) sample(14'h3FFF);
        wait_done("avg16_sat");

        // Holdoff; a trig already high at arm must not start.
        trig = 1'b1;
        cyc(2);
        arm_cfg(16'd1, 3'd0, 16'd5);
        cyc(4);
        check("prehigh_trig_no_start", {busy, adc_enable}, 2'b10);
        trig = 1'b0;
        cyc(1);
        trig = 1'b1;
        lat  = -1;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            if (k == 1) trig = 1'b0;
            if (adc_enable) begin
                lat = k;
                break;
            end
        end
        check("holdoff_latency", lat, 6);
        push(1'b1, 14'h2A5);
        sample(14'h2A5);
        wait_done("holdoff");

        // Backpressure: first word held, tlast word dropped.
        o_tready = 1'b0;
        arm_cfg(16'd2, 3'd1, 16'd0);
        fire_trig();
        sample(14'd4); sample(14'd6);
        check("bp_first_word", {o_tvalid, o_tlast, 14'(o_tdata)}, {2'b10, 14'd5});
        sample(14'd8); sample(14'd10);
        check("bp_held_stable", {o_tvalid, o_tlast, 14'(o_tdata)}, {2'b10, 14'd5});
        check("bp_overflow_done_state", {overflow, adc_enable, busy, done}, 4'b1010);
        cyc(3);
        check("bp_wait_no_done", {busy, done, 14'(o_tdata)}, {2'b10, 14'd5});
        push(1'b0, 14'd5);
        o_tready = 1'b1;
        wait_done("bp");

        // Abort in RUN with a held word, then re-arm.
        o_tready = 1'b0;
        arm_cfg(16'd4, 3'd0, 16'd0);
        check("arm_clears_overflow", overflow, 0);
        fire_trig();
        sample(14'h55); sample(14'h66);
        check("abort_pre_state", {o_tvalid, overflow, adc_enable, 14'(o_tdata)},
              {3'b111, 14'h55});
        dsnap = done_cnt;
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        check("abort_next_cycle", {o_tvalid, o_tlast, adc_enable, adc_clear, busy}, 5'b00010);
        cyc(1);
        check("abort_clear_pulse", {adc_clear, done}, 2'b00);
        cyc(3);
        check("abort_no_done", done_cnt, dsnap);
        o_tready = 1'b1;
        arm_cfg(16'd1, 3'd0, 16'd0);
        check("rearm_clears_overflow", {busy, overflow}, 2'b10);
        fire_trig();
        push(1'b1, 14'h1234);
        sample(14'h1234);
        wait_done("rearm");

        // Edge cases.
        arm_cfg(16'd0, 3'd0, 16'd0);
        check("len0_no_busy", busy, 0);
        cyc(2);
        check("len0_still_idle", busy, 0);
        burst_len = 16'd2;
        arm       = 1'b1;
        abort     = 1'b1;
        cyc(1);
        arm       = 1'b0;
        abort     = 1'b0;
        check("arm_abort_idle", busy, 0);

        // Asynchronous reset mid-RUN.
        o_tready = 1'b0;
        arm_cfg(16'd4, 3'd0, 16'd0);
        fire_trig();
        sample(14'h77);
        check("pre_reset_run", {adc_enable, o_tvalid, busy}, 3'b111);
        #2 rst = 1'b0;
        #1;
        check("async_reset_outputs",
              {adc_enable, adc_clear, o_tvalid, o_tlast, busy, done, overflow, 14'(o_tdata)}, 0);
        cyc(2);
        rst      = 1'b1;
        o_tready = 1'b1;
        cyc(3);

        check("scoreboard_drained", exp_q.size(), 0);
        check("done_total", done_cnt, 6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
